// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM streaming read engine.
// The optional stall counter is enabled by defining BRAM_READER_PERF_EN.
package bram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH       = 2;
   localparam int SKID_PTR_WIDTH   = 1;
   localparam int SKID_COUNT_WIDTH = 2;
   localparam int STALL_WIDTH      = 32;

   // Words already owed to the skid FIFO after this cycle's pop.
   function automatic logic [SKID_COUNT_WIDTH:0] credit_used(
      input logic [SKID_COUNT_WIDTH-1:0] fifo_count,
      input logic                        inflight,
      input logic                        pop
   );
      credit_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/bram_reader_skid.sv
// Two-entry pointer-based FIFO carrying {data, last} from the memory read port
// to the output stream; the head entry drives the stream directly.
module bram_reader_skid
   import bram_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push,
   input  logic [DATA_WIDTH-1:0]       push_data,
   input  logic                        push_last,
   input  logic                        pop,
   output logic [SKID_COUNT_WIDTH-1:0] count,
   output logic                        head_valid,
   output logic [DATA_WIDTH-1:0]       head_data,
   output logic                        head_last
);

   logic [DATA_WIDTH-1:0]       data_r [SKID_DEPTH];
   logic                        last_r [SKID_DEPTH];
   logic [SKID_PTR_WIDTH-1:0]   wr_ptr_r;
   logic [SKID_PTR_WIDTH-1:0]   rd_ptr_r;
   logic [SKID_COUNT_WIDTH-1:0] count_r;
   logic                        pop_s;

   assign pop_s = pop & (count_r != {SKID_COUNT_WIDTH{1'b0}});

   // Storage, pointers and occupancy; the producer guarantees no overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= {SKID_PTR_WIDTH{1'b0}};
         rd_ptr_r <= {SKID_PTR_WIDTH{1'b0}};
         count_r  <= {SKID_COUNT_WIDTH{1'b0}};
         for (int i = 0; i < SKID_DEPTH; i++) begin
            data_r[i] <= {DATA_WIDTH{1'b0}};
            last_r[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            data_r[wr_ptr_r] <= push_data;
            last_r[wr_ptr_r] <= push_last;
            wr_ptr_r         <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign count      = count_r;
   assign head_valid = (count_r != {SKID_COUNT_WIDTH{1'b0}});
   assign head_data  = data_r[rd_ptr_r];
   // A stale entry must never flag last once the FIFO has emptied.
   assign head_last  = last_r[rd_ptr_r] & head_valid;

endmodule

// File: rtl/bram_stream_reader.sv
// Streaming read engine: issues reads to a one-cycle-latency BRAM and presents
// the words as a valid/ready stream. BRAM_READER_PERF_EN adds stall_cycles.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 11,
   parameter int COUNT_WIDTH   = ADDRESS_WIDTH + 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0] cmd_base,
   input  logic [COUNT_WIDTH-1:0]   cmd_count,
   output logic [ADDRESS_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0]    dout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last,
   output logic                     busy
`ifdef BRAM_READER_PERF_EN
   ,
   output logic [STALL_WIDTH-1:0]   stall_cycles
`endif
);

   state_t                      state_r;
   state_t                      state_next_s;
   logic [ADDRESS_WIDTH-1:0]    addr_r;
   logic [COUNT_WIDTH-1:0]      remaining_r;
   logic                        inflight_r;
   logic                        inflight_last_r;
   logic                        cmd_ready_r;
   logic                        busy_r;

   logic                        accept_s;
   logic                        issue_s;
   logic                        final_issue_s;
   logic                        pop_s;
   logic [SKID_COUNT_WIDTH-1:0] fifo_count_s;
   logic                        head_valid_s;
   logic [DATA_WIDTH-1:0]       head_data_s;
   logic                        head_last_s;

   // Next-state, issue credit and command acceptance.
   always_comb begin
      state_next_s  = state_r;
      accept_s      = 1'b0;
      issue_s       = 1'b0;
      final_issue_s = 1'b0;
      pop_s         = head_valid_s & out_ready;
      case (state_r)
         IDLE: begin
            accept_s = cmd_valid;
            if (cmd_valid && (cmd_count != {COUNT_WIDTH{1'b0}})) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            // At most two words may be buffered or on their way out of the memory.
            if (credit_used(fifo_count_s, inflight_r, pop_s) < 3'd2) begin
               issue_s       = 1'b1;
               final_issue_s = (remaining_r == COUNT_WIDTH'(1));
               if (final_issue_s) begin
                  state_next_s = DRAIN;
               end else begin
                  state_next_s = RUN;
               end
            end else begin
               state_next_s = RUN;
            end
         end
         DRAIN: begin
            if (pop_s && head_last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, address/remaining counters and the read-in-flight marker.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r         <= IDLE;
         addr_r          <= {ADDRESS_WIDTH{1'b0}};
         remaining_r     <= {COUNT_WIDTH{1'b0}};
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         cmd_ready_r     <= 1'b1;
         busy_r          <= 1'b0;
      end else begin
         state_r         <= state_next_s;
         cmd_ready_r     <= (state_next_s == IDLE);
         busy_r          <= (state_next_s != IDLE);
         inflight_r      <= issue_s;
         inflight_last_r <= final_issue_s;
         if (accept_s) begin
            addr_r      <= cmd_base;
            remaining_r <= cmd_count;
         end else if (issue_s) begin
            addr_r      <= addr_r + 1'b1;
            remaining_r <= remaining_r - COUNT_WIDTH'(1);
         end
      end
   end

   bram_reader_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clock      (clock),
      .reset      (reset),
      .push       (inflight_r),
      .push_data  (dout),
      .push_last  (inflight_last_r),
      .pop        (pop_s),
      .count      (fifo_count_s),
      .head_valid (head_valid_s),
      .head_data  (head_data_s),
      .head_last  (head_last_s)
   );

`ifdef BRAM_READER_PERF_EN
   logic [STALL_WIDTH-1:0] stall_r;

   // Saturating count of cycles where the consumer holds off a valid word.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_r <= {STALL_WIDTH{1'b0}};
      end else if (accept_s) begin
         stall_r <= {STALL_WIDTH{1'b0}};
      end else if (head_valid_s && !out_ready && (stall_r != {STALL_WIDTH{1'b1}})) begin
         stall_r <= stall_r + 32'd1;
      end
   end

   assign stall_cycles = stall_r;
`endif

   assign raddr     = addr_r;
   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign out_valid = head_valid_s;
   assign out_data  = head_data_s;
   assign out_last  = head_last_s;

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Streaming read engine for the BRAMLike simple-dual-port memory: it drives the read port (`raddr`/`dout`, one-cycle read latency) and presents the words as a valid/ready stream. A command gives a base address and a word count. The block sustains one word per cycle under continuous `out_ready` and never loses data under arbitrary backpressure. It is the read-side counterpart to any block that fills the memory through the write port.

## Interface
- `DATA_WIDTH`, 16, word width; must equal the attached memory's width.
- `ADDRESS_WIDTH`, 11, memory address width.
- `COUNT_WIDTH`, `ADDRESS_WIDTH+1`, width of the word count; allows a full-memory sweep.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_base`  in  ADDRESS_WIDTH  first address.
- `cmd_count`  in  COUNT_WIDTH  number of words to read.
- `raddr`  out  ADDRESS_WIDTH  to memory read address.
- `dout`  in  DATA_WIDTH  from memory; valid one cycle after `raddr`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_last`  out  1  marks the final word of a command.
- `busy`  out  1  high whenever state is not IDLE.
- `stall_cycles`  out  32  present only with BRAM_READER_PERF_EN.

## Operation
- States:
  - IDLE → RUN on the `cmd_valid & cmd_ready` edge when `cmd_count != 0`.
  - With `cmd_count == 0`, the command is accepted and the block stays in IDLE; no beats are produced.
  - RUN → DRAIN on the edge that issues the final address.
  - DRAIN → IDLE on the edge where the last beat pops.
- Issue:
  - An issue happens in RUN when `fifo_count + inflight - pop < 2`, where `pop = out_valid & out_ready`.
  - `inflight` is a 1-bit register set on the edge that issues a read; it marks that `dout` carries a word in the following cycle.
- Capture: when `inflight` is 1, `dout` is pushed into a 2-entry skid FIFO. The credit rule guarantees the FIFO never overflows.
- Address: increments by 1 modulo 2^ADDRESS_WIDTH after each issue, so a sweep past the top wraps to 0.
- `out_last`:
  - Travels with the final word through the FIFO.
  - Is asserted together with `out_valid` on that word only.
- Stream rules:
  - `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
  - `out_valid` never drops without a pop.
- Memory coherence: the block does not arbitrate the write port. A write to an address that is being read in the same cycle returns the old data (read-first).
- Reset:
  - Takes effect in any state, including mid-command.
  - The next cycle has state IDLE, an empty FIFO, `inflight=0`, `out_valid=0`, `out_last=0`, `busy=0`, `cmd_ready=1`, `raddr=0`, and `stall_cycles=0`.
  - The in-flight read is discarded.

## Timing
- The command handshake happens at edge E0.
- `raddr=cmd_base` is presented in the cycle after E0; the memory samples it at E1.
- The word is pushed at E2, and `out_valid` is high in the cycle after E2. First-word latency is therefore 3 cycles from acceptance.
- With `out_ready` held at 1, N words finish in N+2 cycles after acceptance and stream with no bubbles.
- After `out_ready` deasserts, at most 2 further words are buffered and issue stalls. Once `out_ready` reasserts, full rate resumes with no bubble.
- `cmd_ready` returns to 1 in the cycle after the last pop, so back-to-back commands have a 3-cycle gap between streams.

## Configuration
- `BRAM_READER_PERF_EN` defined:
  - Adds the `stall_cycles` port: a 32-bit saturating counter of cycles with `out_valid & !out_ready`.
  - The counter clears on `reset` and at command acceptance.
- `BRAM_READER_PERF_EN` undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Package `bram_stream_pkg`:
  - State enum `{IDLE, RUN, DRAIN}`.
  - FIFO depth constant `SKID_DEPTH = 2`.
  - Stall counter width constant `STALL_WIDTH = 32`.
- Sub-module `bram_reader_skid`:
  - 2-entry FIFO of {data, last}.
  - Exposes `push`, `pop`, `count`, and head outputs.
  - Pointer-based, with a synchronous active-high reset.
- Top level holds the FSM, the address/remaining counters, `inflight`, and the optional perf counter.

## Test plan
- Memory preloaded with mem[i]=i; command base=5, count=4, `out_ready=1`:
  - Beats are 5,6,7,8 on consecutive cycles, the first 3 cycles after acceptance.
  - `out_last` is high only on 8.
- Base=2046, count=4, ADDRESS_WIDTH=11 → beats are mem[2046], mem[2047], mem[0], mem[1].
- Count=16, `out_ready` toggling 1,0,0,1,… → all 16 words arrive in order, with none dropped or duplicated. Data is held stable during stalls, and the FIFO count never exceeds 2.
- Count=0 → no `out_valid`, `busy` stays 0, and `cmd_ready` is 1 on the next cycle.
- Reset asserted mid-stream on word 3 of count=10:
  - The next cycle shows `out_valid=0` and `busy=0`.
  - A new command base=0, count=2 then yields exactly mem[0], mem[1].
- With BRAM_READER_PERF_EN, count=4 and `out_ready` low for 5 cycles while `out_valid` is high → `stall_cycles=5` at command end.
